// File: rtl/mgmt_master_pkg.sv
// rtl/mgmt_master_pkg.sv - shared state encodings and defaults for the mgmt bus initiator
package mgmt_master_pkg;

  typedef enum logic [1:0] {
    MGMT_IDLE = 2'd0,
    MGMT_REQ  = 2'd1,
    MGMT_GAP  = 2'd2
  } mgmt_state_t;

  // Responders size their worst-case ack latency against this bound.
  localparam int MGMT_TIMEOUT    = 16;
  localparam int MGMT_GAP_CYCLES = 2;

  // The shared counter holds either the timeout count (up to TIMEOUT-1) or the gap load (GAP).
  function automatic int cnt_width(input int timeout, input int gap);
    int span;
    span = (timeout > gap) ? timeout : gap + 1;
    return $clog2(span) + 1;
  endfunction

endpackage

// File: rtl/mgmt_master.sv
// rtl/mgmt_master.sv - mgmt bus initiator: one command in flight, ack/timeout response
module mgmt_master
  import mgmt_master_pkg::*;
#(
  parameter int TIMEOUT = MGMT_TIMEOUT,
  parameter int GAP     = MGMT_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [31:0] cmd_adr,
  input  logic        cmd_rwn,
  input  logic [1:0]  cmd_wen,
  input  logic [31:0] cmd_txd,
  output logic        rsp_vld,
  output logic        rsp_err,
  output logic [31:0] rsp_rxd,
  output logic        mgmt_req,
  output logic [31:0] mgmt_adr,
  output logic        mgmt_rwn,
  output logic [1:0]  mgmt_wen,
  output logic [31:0] mgmt_txd,
  input  logic        mgmt_ack,
  input  logic        mgmt_rxe,
  input  logic [31:0] mgmt_rxd
);

  localparam int            CW       = cnt_width(TIMEOUT, GAP);
  localparam logic [CW-1:0] TERM     = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mgmt_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept, done_ack, done_to;

  logic          cmd_rdy_n, mgmt_req_n, rsp_vld_n, rsp_err_n;
  logic [31:0]   rsp_rxd_n, mgmt_adr_n, mgmt_txd_n;
  logic          mgmt_rwn_n;
  logic [1:0]    mgmt_wen_n;

  assign accept   = (state == MGMT_IDLE) && cmd_vld;
  assign done_ack = (state == MGMT_REQ) && mgmt_ack;
  assign done_to  = (state == MGMT_REQ) && !mgmt_ack && (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MGMT_GAP;
      cnt   <= GAP_LOAD;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // One counter: counts up while waiting for ack, counts down through the gap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      MGMT_IDLE: begin
        if (cmd_vld) begin
          state_n = MGMT_REQ;
          cnt_n   = '0;
        end
      end
      MGMT_REQ: begin
        if (mgmt_ack || (cnt == TERM)) begin
          state_n = MGMT_GAP;
          cnt_n   = GAP_LOAD;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      MGMT_GAP: begin
        if (cnt <= CNT_ONE) begin
          state_n = MGMT_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: begin
        state_n = MGMT_GAP;
        cnt_n   = GAP_LOAD;
      end
    endcase
  end

  always_comb begin
    cmd_rdy_n  = (state_n == MGMT_IDLE);
    mgmt_req_n = (state_n == MGMT_REQ);
    rsp_vld_n  = done_ack || done_to;
    rsp_err_n  = done_to || (done_ack && mgmt_rwn && !mgmt_rxe);
    rsp_rxd_n  = (done_ack && mgmt_rwn && mgmt_rxe) ? mgmt_rxd : 32'd0;
    mgmt_adr_n = accept ? cmd_adr : mgmt_adr;
    mgmt_rwn_n = accept ? cmd_rwn : mgmt_rwn;
    mgmt_wen_n = accept ? cmd_wen : mgmt_wen;
    mgmt_txd_n = accept ? cmd_txd : mgmt_txd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_rdy  <= 1'b0;
      mgmt_req <= 1'b0;
      rsp_vld  <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_rxd  <= 32'd0;
      mgmt_adr <= 32'd0;
      mgmt_rwn <= 1'b0;
      mgmt_wen <= 2'd0;
      mgmt_txd <= 32'd0;
    end else begin
      cmd_rdy  <= cmd_rdy_n;
      mgmt_req <= mgmt_req_n;
      rsp_vld  <= rsp_vld_n;
      rsp_err  <= rsp_err_n;
      rsp_rxd  <= rsp_rxd_n;
      mgmt_adr <= mgmt_adr_n;
      mgmt_rwn <= mgmt_rwn_n;
      mgmt_wen <= mgmt_wen_n;
      mgmt_txd <= mgmt_txd_n;
    end
  end

endmodule

// File: doc/mgmt_master.md
Name: mgmt_master

Overview:
- Initiator end of the mgmt bus, the counterpart of the responders on that bus (e.g. the interrupt controller's priority regmap).
- Accepts single read/write commands from a core-side valid/ready port and drives one mgmt transaction at a time.
- Waits for ack, captures read data and returns a one-cycle response.
- Provides a timeout so an unmapped address cannot hang the core.

Parameters:
- TIMEOUT, 16: cycles from mgmt_req rising with no mgmt_ack before the transaction is aborted with error; legal range 4..255.
- GAP, 2: minimum cycles mgmt_req stays low between transactions, so the responder's busy/issue logic re-arms; legal range ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command accepted when cmd_vld && cmd_rdy
- cmd_adr  in  32  target address
- cmd_rwn  in  1  1 = read, 0 = write
- cmd_wen  in  2  write enables, passed through
- cmd_txd  in  32  write data
- rsp_vld  out  1  one-cycle response pulse
- rsp_err  out  1  timeout, or read acked without mgmt_rxe; valid with rsp_vld
- rsp_rxd  out  32  read data; valid with rsp_vld
- mgmt_req  out  1  request level, held until ack or timeout
- mgmt_adr  out  32  address, stable while mgmt_req=1
- mgmt_rwn  out  1  read/not-write, stable while mgmt_req=1
- mgmt_wen  out  2  write enables, stable while mgmt_req=1
- mgmt_txd  out  32  write data, stable while mgmt_req=1
- mgmt_ack  in  1  responder ack, single-cycle pulse
- mgmt_rxe  in  1  read data valid, same cycle as ack
- mgmt_rxd  in  32  read data, same cycle as ack, 0 otherwise

Behaviour:
- Reset values: cmd_rdy=0, rsp_vld=0, rsp_err=0, rsp_rxd=0, mgmt_req=0, mgmt_adr/rwn/wen/txd=0, state=GAP with gap counter = GAP. Reset mid-transaction drops mgmt_req immediately (async) and no response is produced.
- All outputs are registered.
- States:
  - IDLE: cmd_rdy=1. On cmd_vld, register adr/rwn/wen/txd onto the mgmt_* outputs, set mgmt_req=1 next cycle, clear the timeout counter, go to REQ.
  - REQ: cmd_rdy=0. Counter increments each cycle.
    - On mgmt_ack: mgmt_req=0 next cycle; rsp_vld=1 next cycle; rsp_rxd = mgmt_rxe ? mgmt_rxd : 0; rsp_err = mgmt_rwn && !mgmt_rxe. Go to GAP.
    - Else, when the counter reaches TIMEOUT-1: mgmt_req=0; rsp_vld=1, rsp_err=1, rsp_rxd=0. Go to GAP.
    - Ack in the same cycle as the timeout terminal count: ack wins, no error.
  - GAP: mgmt_req=0, cmd_rdy=0 for GAP cycles, then go to IDLE.
    - Any mgmt_ack/mgmt_rxe arriving in GAP or IDLE (late ack after a timeout) is ignored and produces no response.
- Latency, with a responder that acks 2 cycles after seeing req:
  - cmd accept at cycle t → mgmt_req high t+1 → ack t+3 → rsp_vld t+4.
  - Next cmd_rdy at t+4+GAP.
- rsp_vld is a single pulse with no backpressure; the consumer must sample it.
- mgmt_* outputs hold their last values while mgmt_req=0; only mgmt_req qualifies them.
- Write transactions return rsp_rxd=0 and rsp_err=0 on ack; mgmt_rxe is don't-care for writes.
- Counter width is $clog2(TIMEOUT)+1; no wrap occurs because REQ exits at TIMEOUT-1.

Decomposition:
- Shared defines.v gets:
  - state encodings MGMT_IDLE=2'd0, MGMT_REQ=2'd1, MGMT_GAP=2'd2.
  - default MGMT_TIMEOUT, which the interrupt controller and other responders use to bound their ack latency.
- Single module. The timeout and gap counters share one register, since they are never active at the same time; no sub-module.

Test Plan:
- Read hit: cmd_vld, adr=0x..IRQ base+3, rwn=1; responder acks with rxe=1, rxd=0x0000001A two cycles after req → rsp_vld once, rsp_rxd=0x1A, rsp_err=0; mgmt_req low on the following cycle.
- Write: rwn=1'b0, wen=2'b11, txd=0x5; ack with no rxe → rsp_vld, rsp_err=0, rsp_rxd=0. mgmt_adr/txd/wen stay stable for the whole req window.
- Timeout: address unmapped, no ack → mgmt_req drops after exactly 16 cycles high; rsp_err=1, rsp_rxd=0. A late ack injected 1 cycle later produces no rsp_vld.
- Back-to-back: cmd_vld held with 3 queued commands → mgmt_req has ≥GAP (2) low cycles between transactions; 3 responses in order; cmd_rdy high exactly one cycle per accept.
- Read without rxe: rwn=1, ack with rxe=0 → rsp_err=1, rsp_rxd=0.
- Reset mid-REQ: assert rst on cycle 2 of req → mgmt_req=0 asynchronously, no rsp_vld. After release, cmd_rdy rises after GAP cycles.
